nn_frame_controller: RTL and testbench
======================================

NN_FRAME_CONTROLLER -- requirements
Module: nn_frame_controller

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DW, 8, signed data word width.
- N_IN, 2, network input words per frame (N_IN >= 1).
- N_OUT, 1, network output words per frame (N_OUT >= 1).
- AW_IN = max(1, clog2(N_IN)); AW_OUT = max(1, clog2(N_OUT)); both derived, not user-set.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  reset: synchronous, active-high.
- fill  in  1  input-word strobe.
- in_data  in  DW signed  input word.
- ack_fill  out  1  all N_IN words loaded.
- req  in  1  level request to run inference.
- ack_network  out  1  frame result fully streamed.
- clear  in  1  abort and return to loading without reset.
- chain_req  out  1  level request to layer chain.
- chain_ack  in  1  layer chain done.
- in_rd_addr  in  AW_IN  layer-side input read address.
- in_rd_data  out  DW signed  input word, registered, 1-cycle latency.
- res_addr  out  AW_OUT  result select toward last layer.
- res_data  in  DW signed  result word at res_addr, combinational.
- out_valid / out_ready  out / in  1 / 1  result stream handshake.
- out_data  out  DW signed  result word.
- out_last  out  1  marks word N_OUT-1.

Function
REQ-003 States: LOAD, READY, RUN, STREAM, DONE; one state register.
REQ-004 LOAD: each cycle with fill=1 writes in_data to mem[wr_ptr] and increments wr_ptr; one word per cycle, no gap required.
REQ-005 The write at wr_ptr=N_IN-1 moves to READY; ack_fill=1 from the next cycle, held until clear or rst.
REQ-006 fill is ignored outside LOAD; inputs are never overwritten by extra fill pulses.
REQ-007 READY: req=1 -> RUN with chain_req=1 from the next cycle; req in LOAD is not latched.
REQ-008 RUN: chain_req held 1 until chain_ack=1 is sampled; next cycle chain_req=0, state STREAM, rd_idx=0; chain_ack is ignored outside RUN.
REQ-009 STREAM: res_addr=rd_idx; output register loads res_data, rd_idx increments, when out_valid=0 or out_ready=1; sustains one word per cycle under continuous out_ready.
REQ-010 out_data/out_valid/out_last stable while out_valid=1 and out_ready=0; out_last=1 only with word N_OUT-1.
REQ-011 Transfer of the out_last word -> DONE; out_valid=0, ack_network=1 next cycle.
REQ-012 DONE: ack_network held while req=1; req=0 -> READY, ack_network=0; a new req reruns with the retained inputs (rerun without reload).
REQ-013 clear=1 from any state: next cycle LOAD, wr_ptr=0, ack_fill=0, chain_req=0, out_valid=0, ack_network=0; memory contents kept but stale.
REQ-014 clear with fill in the same cycle: clear wins, word dropped; rst with clear: rst wins, same effect.
REQ-015 Words are stored and forwarded bit-exact; no arithmetic on data; pointers wrap only via reset to 0, never modulo.
REQ-016 in_rd_data = mem[in_rd_addr] registered every cycle regardless of state; addresses >= N_IN return undefined data.

Reset
REQ-017 rst=1: state LOAD, wr_ptr=0, rd_idx=0; ack_fill, ack_network, chain_req, out_valid, out_last=0; out_data=0; res_addr=0; memory not reset.
REQ-018 Reset mid-RUN or mid-STREAM discards the frame; no handshake output glitches high.

Structure
REQ-019 Shared package nn_pkg holds the state enum, the clog2 helper and DW default.
REQ-020 One sub-module nn_word_ram: N_IN x DW, one write port, one registered read port.

Verification
REQ-021 N_IN=2: fill with 5 then -3 on consecutive cycles -> ack_fill=1 next cycle; in_rd_addr=1 -> in_rd_data=-3 one cycle later.
REQ-022 req=1, chain_ack after 4 cycles -> chain_req high exactly 4 cycles + 1 for ack; N_OUT=1, res_data=7 -> out_valid, out_data=7, out_last=1; ack_network=1 after transfer.
REQ-023 N_OUT=3, res_data={1,2,3}, out_ready low 2 cycles on word 2 -> words 1,2,3 in order, word 2 held stable, out_last only on 3.
REQ-024 After DONE, drop req then raise it -> second frame streams identical results, no refill, ack_fill stays 1.
REQ-025 clear in STREAM after word 1 -> out_valid=0, state LOAD, ack_fill=0; new fill 9,4 -> in_rd_data gives 9,4.
REQ-026 rst asserted during RUN -> all outputs 0 next cycle; late chain_ack ignored.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and elaboration helpers for the NN frame controller slice.
package nn_pkg;

  localparam int DW_DEF = 8;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_READY,
    ST_RUN,
    ST_STREAM,
    ST_DONE
  } nn_state_e;

  function automatic int nn_clog2(input int value);
    int result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Address width for a table of 'depth' entries; never narrower than one bit.
  function automatic int nn_aw(input int depth);
    return (nn_clog2(depth) < 1) ? 1 : nn_clog2(depth);
  endfunction

endpackage

// File: rtl/nn_word_ram.sv
// Input-frame word store: one synchronous write port, one registered read port.
module nn_word_ram
  import nn_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 2,
  parameter int AW    = nn_aw(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic signed [DW-1:0] wr_data_i,
  input  logic [AW-1:0]        rd_addr_i,
  output logic signed [DW-1:0] rd_data_o
);

  logic signed [DW-1:0] mem_q [DEPTH];
  logic signed [DW-1:0] rd_data_q;

  // NOTE: the array has no reset; contents persist across reset/clear and the read path
  // stays a plain register so the store can map onto RAM macros.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/nn_frame_controller.sv
// Frame sequencer: loads network inputs, hands off to the layer chain, then
// streams the result words out over a valid/ready port.
module nn_frame_controller
  import nn_pkg::*;
#(
  parameter int  DW     = DW_DEF,
  parameter int  N_IN   = 2,
  parameter int  N_OUT  = 1,
  localparam int AW_IN  = nn_aw(N_IN),
  localparam int AW_OUT = nn_aw(N_OUT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fill,
  input  logic signed [DW-1:0] in_data,
  output logic                 ack_fill,
  input  logic                 req,
  output logic                 ack_network,
  input  logic                 clear,
  output logic                 chain_req,
  input  logic                 chain_ack,
  input  logic [AW_IN-1:0]     in_rd_addr,
  output logic signed [DW-1:0] in_rd_data,
  output logic [AW_OUT-1:0]    res_addr,
  input  logic signed [DW-1:0] res_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic                 out_last
);

  // One spare pointer bit so the count can reach N_IN / N_OUT without folding back.
  localparam logic [AW_IN:0]  LAST_IN  = (AW_IN + 1)'(N_IN - 1);
  localparam logic [AW_OUT:0] LAST_OUT = (AW_OUT + 1)'(N_OUT - 1);

  nn_state_e            state_q, state_d;
  logic [AW_IN:0]       wr_ptr_q, wr_ptr_d;
  logic [AW_OUT:0]      rd_idx_q, rd_idx_d;
  logic                 ack_fill_q, ack_fill_d;
  logic                 ack_network_q, ack_network_d;
  logic                 chain_req_q, chain_req_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic signed [DW-1:0] out_data_q, out_data_d;
  logic                 ram_we;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_idx_d      = rd_idx_q;
    ack_fill_d    = ack_fill_q;
    ack_network_d = ack_network_q;
    chain_req_d   = chain_req_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    out_data_d    = out_data_q;
    ram_we        = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        if (fill) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LAST_IN) begin
            state_d    = ST_READY;
            ack_fill_d = 1'b1;
          end
        end
      end
      ST_READY: begin
        if (req) begin
          state_d     = ST_RUN;
          chain_req_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (chain_ack) begin
          state_d     = ST_STREAM;
          chain_req_d = 1'b0;
          rd_idx_d    = '0;
        end
      end
      ST_STREAM: begin
        if (out_valid_q && out_ready && out_last_q) begin
          state_d       = ST_DONE;
          out_valid_d   = 1'b0;
          out_last_d    = 1'b0;
          ack_network_d = 1'b1;
        end else if (!out_valid_q || out_ready) begin
          out_valid_d = 1'b1;
          out_data_d  = res_data;
          out_last_d  = (rd_idx_q == LAST_OUT);
          rd_idx_d    = rd_idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (!req) begin
          state_d       = ST_READY;
          ack_network_d = 1'b0;
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // Abort overrides everything, including a same-cycle fill; the stored words are left as-is.
    if (clear) begin
      state_d       = ST_LOAD;
      wr_ptr_d      = '0;
      rd_idx_d      = '0;
      ack_fill_d    = 1'b0;
      ack_network_d = 1'b0;
      chain_req_d   = 1'b0;
      out_valid_d   = 1'b0;
      out_last_d    = 1'b0;
      ram_we        = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_LOAD;
      wr_ptr_q      <= '0;
      rd_idx_q      <= '0;
      ack_fill_q    <= 1'b0;
      ack_network_q <= 1'b0;
      chain_req_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_idx_q      <= rd_idx_d;
      ack_fill_q    <= ack_fill_d;
      ack_network_q <= ack_network_d;
      chain_req_q   <= chain_req_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      out_data_q    <= out_data_d;
    end
  end

  nn_word_ram #(
    .DW    (DW),
    .DEPTH (N_IN),
    .AW    (AW_IN)
  ) u_in_ram (
    .clk       (clk),
    .we_i      (ram_we && !rst),
    .wr_addr_i (wr_ptr_q[AW_IN-1:0]),
    .wr_data_i (in_data),
    .rd_addr_i (in_rd_addr),
    .rd_data_o (in_rd_data)
  );

  assign ack_fill    = ack_fill_q;
  assign ack_network = ack_network_q;
  assign chain_req   = chain_req_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_data    = out_data_q;
  assign res_addr    = rd_idx_q[AW_OUT-1:0];

endmodule

// File: tb/tb_nn_frame_controller.sv
// Scoreboard bench: two controller instances (single-word and three-word results)
// driven by directed vectors; monitors pop expected result words on each transfer.
module tb_nn_frame_controller;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];

  // Instance A: N_IN=2, N_OUT=1
  logic              a_fill, a_req, a_clear, a_chain_ack, a_out_ready;
  logic signed [7:0] a_in_data, a_res_data, a_in_rd_data, a_out_data;
  logic [0:0]        a_in_rd_addr, a_res_addr;
  logic              a_ack_fill, a_ack_network, a_chain_req, a_out_valid, a_out_last;

  // Instance B: N_IN=2, N_OUT=3
  logic              b_fill, b_req, b_clear, b_chain_ack, b_out_ready;
  logic signed [7:0] b_in_data, b_res_data, b_in_rd_data, b_out_data;
  logic [0:0]        b_in_rd_addr;
  logic [1:0]        b_res_addr;
  logic              b_ack_fill, b_ack_network, b_chain_req, b_out_valid, b_out_last;

  nn_frame_controller #(.DW(8), .N_IN(2), .N_OUT(1)) dut_a (
    .clk(clk), .rst(rst), .fill(a_fill), .in_data(a_in_data), .ack_fill(a_ack_fill),
    .req(a_req), .ack_network(a_ack_network), .clear(a_clear), .chain_req(a_chain_req),
    .chain_ack(a_chain_ack), .in_rd_addr(a_in_rd_addr), .in_rd_data(a_in_rd_data),
    .res_addr(a_res_addr), .res_data(a_res_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last)
  );

  nn_frame_controller #(.DW(8), .N_IN(2), .N_OUT(3)) dut_b (
    .clk(clk), .rst(rst), .fill(b_fill), .in_data(b_in_data), .ack_fill(b_ack_fill),
    .req(b_req), .ack_network(b_ack_network), .clear(b_clear), .chain_req(b_chain_req),
    .chain_ack(b_chain_ack), .in_rd_addr(b_in_rd_addr), .in_rd_data(b_in_rd_data),
    .res_addr(b_res_addr), .res_data(b_res_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last)
  );

  // Last-layer model for B: result words 1,2,3 at addresses 0,1,2.
  always_comb begin
    b_res_data = 8'sd0;
    case (b_res_addr)
      2'd0:    b_res_data = 8'sd1;
      2'd1:    b_res_data = 8'sd2;
      2'd2:    b_res_data = 8'sd3;
      default: b_res_data = 8'sd0;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor A: compare every transferred word against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && a_out_valid && a_out_ready) begin
        if (exp_a.size() == 0) begin
          check("a_word_expected", exp_a.size(), 1);
        end else begin
          e = exp_a.pop_front();
          check("a_out_data", int'(a_out_data), e.data);
          check("a_out_last", int'(a_out_last), int'(e.last));
        end
      end
    end
  end

  // Monitor B: as above, plus the presented word must stay stable while stalled.
  initial begin
    exp_t              e;
    bit                held_v;
    logic signed [7:0] held_data;
    logic              held_last;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !b_out_valid) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("b_hold_data", int'(b_out_data), int'(held_data));
          check("b_hold_last", int'(b_out_last), int'(held_last));
        end
        if (b_out_ready) begin
          held_v = 1'b0;
          if (exp_b.size() == 0) begin
            check("b_word_expected", exp_b.size(), 1);
          end else begin
            e = exp_b.pop_front();
            check("b_out_data", int'(b_out_data), e.data);
            check("b_out_last", int'(b_out_last), int'(e.last));
          end
        end else begin
          held_v    = 1'b1;
          held_data = b_out_data;
          held_last = b_out_last;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int stall;

    rst = 1'b1;
    a_fill = 0; a_req = 0; a_clear = 0; a_chain_ack = 0; a_out_ready = 1;
    a_in_data = 0; a_res_data = 0; a_in_rd_addr = 0;
    b_fill = 0; b_req = 0; b_clear = 0; b_chain_ack = 0; b_out_ready = 1;
    b_in_data = 0; b_in_rd_addr = 0;
    repeat (2) step();

    check("rst_a_ack_fill", int'(a_ack_fill), 0);
    check("rst_a_ack_network", int'(a_ack_network), 0);
    check("rst_a_chain_req", int'(a_chain_req), 0);
    check("rst_a_out_valid", int'(a_out_valid), 0);
    check("rst_a_out_last", int'(a_out_last), 0);
    check("rst_a_out_data", int'(a_out_data), 0);
    check("rst_a_res_addr", int'(a_res_addr), 0);
    check("rst_b_res_addr", int'(b_res_addr), 0);
    rst = 1'b0;

    // A: load 5, -3; extra fill in READY must be ignored
    a_fill = 1; a_in_data = 8'sd5; step();
    check("a_ack_fill_one_word", int'(a_ack_fill), 0);
    a_in_data = -8'sd3; step();
    check("a_ack_fill_loaded", int'(a_ack_fill), 1);
    a_in_data = 8'sd99; step();
    a_fill = 0; a_in_rd_addr = 1'b1; step();
    check("a_rd_addr1", int'(a_in_rd_data), -3);
    a_in_rd_addr = 1'b0; step();
    check("a_rd_addr0", int'(a_in_rd_data), 5);

    // A: chain handshake with ack after 4 cycles, single result word 7
    exp_a.push_back('{7, 1'b1});
    a_res_data = 8'sd7; a_req = 1; step();
    for (int i = 0; i < 4; i++) begin
      check("a_chain_req_wait", int'(a_chain_req), 1);
      step();
    end
    a_chain_ack = 1;
    check("a_chain_req_ack_cycle", int'(a_chain_req), 1);
    step();
    a_chain_ack = 0;
    check("a_chain_req_drop", int'(a_chain_req), 0);
    n = 0;
    while (!a_ack_network && n < 20) begin step(); n++; end
    check("a_ack_network_set", int'(a_ack_network), 1);
    check("a_out_valid_done", int'(a_out_valid), 0);
    step();
    check("a_ack_network_held", int'(a_ack_network), 1);
    a_req = 0; step();
    check("a_ack_network_drop", int'(a_ack_network), 0);
    check("a_ack_fill_kept", int'(a_ack_fill), 1);

    // B: load 10, 20
    b_fill = 1; b_in_data = 8'sd10; step();
    b_in_data = 8'sd20; step();
    b_fill = 0;
    check("b_ack_fill_loaded", int'(b_ack_fill), 1);

    // B: three-word stream, word 2 stalled for two cycles
    exp_b.push_back('{1, 1'b0});
    exp_b.push_back('{2, 1'b0});
    exp_b.push_back('{3, 1'b1});
    b_req = 1; step();
    check("b_chain_req_run", int'(b_chain_req), 1);
    b_chain_ack = 1; step();
    b_chain_ack = 0;
    check("b_chain_req_drop", int'(b_chain_req), 0);
    stall = 2; n = 0;
    while (!b_ack_network && n < 30) begin
      b_out_ready = !(b_out_valid && b_out_data == 8'sd2 && stall > 0);
      if (!b_out_ready) stall--;
      step(); n++;
    end
    b_out_ready = 1;
    check("b_ack_network_frame1", int'(b_ack_network), 1);
    check("b_stall_cycles_used", stall, 0);
    check("b_out_valid_done", int'(b_out_valid), 0);
    b_req = 0; step();
    check("b_ack_network_drop", int'(b_ack_network), 0);

    // B: rerun on retained inputs
    exp_b.push_back('{1, 1'b0});
    exp_b.push_back('{2, 1'b0});
    exp_b.push_back('{3, 1'b1});
    b_req = 1; step();
    b_chain_ack = 1; step();
    b_chain_ack = 0;
    n = 0;
    while (!b_ack_network && n < 30) begin step(); n++; end
    check("b_ack_network_frame2", int'(b_ack_network), 1);
    check("b_ack_fill_rerun", int'(b_ack_fill), 1);
    b_in_rd_addr = 1'b0; step();
    check("b_rd_retained0", int'(b_in_rd_data), 10);
    b_in_rd_addr = 1'b1; step();
    check("b_rd_retained1", int'(b_in_rd_data), 20);
    b_req = 0; step();

    // B: clear mid-stream after word 1
    exp_b.push_back('{1, 1'b0});
    b_req = 1; step();
    b_chain_ack = 1; step();
    b_chain_ack = 0; b_req = 0;
    n = 0;
    while (!b_out_valid && n < 10) begin step(); n++; end
    check("b_word1_presented", int'(b_out_valid), 1);
    step();
    b_out_ready = 0; b_clear = 1; step();
    b_clear = 0; b_out_ready = 1;
    check("b_clear_out_valid", int'(b_out_valid), 0);
    check("b_clear_ack_fill", int'(b_ack_fill), 0);
    check("b_clear_chain_req", int'(b_chain_req), 0);
    check("b_clear_ack_network", int'(b_ack_network), 0);

    // B: clear together with fill drops the word, then refill 9, 4
    b_clear = 1; b_fill = 1; b_in_data = 8'sd55; step();
    b_clear = 0; b_in_data = 8'sd9; step();
    check("b_refill_one_word", int'(b_ack_fill), 0);
    b_in_data = 8'sd4; step();
    b_fill = 0;
    check("b_refill_loaded", int'(b_ack_fill), 1);
    b_in_rd_addr = 1'b0; step();
    check("b_rd_refill0", int'(b_in_rd_data), 9);
    b_in_rd_addr = 1'b1; step();
    check("b_rd_refill1", int'(b_in_rd_data), 4);

    // B: reset during RUN, then a late chain_ack
    b_req = 1; step();
    check("b_chain_req_run2", int'(b_chain_req), 1);
    step();
    b_req = 0; rst = 1; step();
    check("rstrun_chain_req", int'(b_chain_req), 0);
    check("rstrun_ack_fill", int'(b_ack_fill), 0);
    check("rstrun_out_valid", int'(b_out_valid), 0);
    check("rstrun_ack_network", int'(b_ack_network), 0);
    check("rstrun_out_last", int'(b_out_last), 0);
    check("rstrun_out_data", int'(b_out_data), 0);
    check("rstrun_res_addr", int'(b_res_addr), 0);
    rst = 0; b_chain_ack = 1; step();
    b_chain_ack = 0;
    check("late_ack_chain_req", int'(b_chain_req), 0);
    check("late_ack_out_valid", int'(b_out_valid), 0);
    step();
    check("late_ack_out_valid2", int'(b_out_valid), 0);
    check("late_ack_ack_fill", int'(b_ack_fill), 0);

    step();
    check("a_scoreboard_drained", exp_a.size(), 0);
    check("b_scoreboard_drained", exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
